// File: rtl/approx_adder_error_profiler.sv
// rtl/approx_adder_error_profiler.sv - exhaustive error-statistics sweep for an approximate adder under test
// Drives every operand pair, compares the returned sum with the exact sum and accumulates statistics.
module approx_adder_error_profiler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2*WIDTH+1,
  parameter int SUM_W = 3*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [WIDTH-1:0] dut_in1,
  output logic [WIDTH-1:0] dut_in2,
  input  logic [WIDTH:0]   dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   max_abs_err,
  output logic [WIDTH-1:0] worst_in1,
  output logic [WIDTH-1:0] worst_in2,
  output logic [SUM_W-1:0] sum_abs_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH:0]     exact;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH+1:0]   diff_neg;
  logic [WIDTH:0]     abs_err;
  logic [2*WIDTH-1:0] pair;
  logic [2*WIDTH-1:0] pair_next;
  logic               last_pair;

  assign pair      = {dut_in1, dut_in2};
  assign pair_next = pair + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign last_pair = &pair;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // One extra sign bit keeps the difference from wrapping; its magnitude always fits WIDTH+1 bits.
  always_comb begin
    exact    = {1'b0, dut_in1} + {1'b0, dut_in2};
    diff     = {1'b0, dut_out} - {1'b0, exact};
    diff_neg = -diff;
    abs_err  = diff[WIDTH+1] ? diff_neg[WIDTH:0] : diff[WIDTH:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dut_in1     <= '0;
      dut_in2     <= '0;
      err_count   <= '0;
      max_abs_err <= '0;
      worst_in1   <= '0;
      worst_in2   <= '0;
      sum_abs_err <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            dut_in1     <= '0;
            dut_in2     <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            worst_in1   <= '0;
            worst_in2   <= '0;
            sum_abs_err <= '0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (abs_err != '0)
              err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            sum_abs_err <= sum_abs_err + {{(SUM_W-WIDTH-1){1'b0}}, abs_err};
            // Strict compare: the earliest pair reaching the maximum is kept.
            if (abs_err > max_abs_err) begin
              max_abs_err <= abs_err;
              worst_in1   <= dut_in1;
              worst_in2   <= dut_in2;
            end
            {dut_in1, dut_in2} <= pair_next;
            if (last_pair)
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_error_profiler.sv
// tb/tb_approx_adder_error_profiler.sv - self-checking bench for approx_adder_error_profiler
module tb_approx_adder_error_profiler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // 8-bit instance, stuck-at-zero adder under test
  logic        rst8, start8, hold8;
  logic [7:0]  in1_8, in2_8, w1_8, w2_8;
  logic [8:0]  out8, max8;
  logic        busy8, done8;
  logic [16:0] err8;
  logic [24:0] sum8;
  assign out8 = 9'd0;

  // 4-bit instance, selectable adder model
  logic        rst4, start4, hold4;
  logic [3:0]  in1_4, in2_4, w1_4, w2_4;
  logic [4:0]  out4, max4;
  logic        busy4, done4;
  logic [8:0]  err4;
  logic [12:0] sum4;
  int          mode4 = 0;
  logic [4:0]  mask_tab [256];

  approx_adder_error_profiler #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .hold(hold8),
    .dut_in1(in1_8), .dut_in2(in2_8), .dut_out(out8),
    .busy(busy8), .done(done8), .err_count(err8), .max_abs_err(max8),
    .worst_in1(w1_8), .worst_in2(w2_8), .sum_abs_err(sum8)
  );

  approx_adder_error_profiler #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .hold(hold4),
    .dut_in1(in1_4), .dut_in2(in2_4), .dut_out(out4),
    .busy(busy4), .done(done4), .err_count(err4), .max_abs_err(max4),
    .worst_in1(w1_4), .worst_in2(w2_4), .sum_abs_err(sum4)
  );

  // Adder models: 0 exact, 1 stuck-at-zero, 2 LSB flip, 3 random per-pair error mask
  function automatic int model4(input int mode, input int a, input int b);
    int ex;
    ex = a + b;
    case (mode)
      0:       return ex;
      1:       return 0;
      2:       return ex ^ 1;
      default: return ex ^ int'(mask_tab[a*16+b]);
    endcase
  endfunction

  always_comb out4 = 5'(model4(mode4, int'(in1_4), int'(in2_4)));

  // Reference statistics: walk all pairs in sweep order with plain integer arithmetic
  task automatic ref4(input int mode, output int e_err, output int e_max,
                      output int e_w1, output int e_w2, output int e_sum);
    int ex, o, e;
    e_err = 0; e_max = 0; e_w1 = 0; e_w2 = 0; e_sum = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ex = a + b;
        o  = model4(mode, a, b);
        e  = (o > ex) ? o - ex : ex - o;
        if (e != 0) e_err++;
        e_sum += e;
        if (e > e_max) begin
          e_max = e; e_w1 = a; e_w2 = b;
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_stats4(input string tag, input int e_err, input int e_max,
                            input int e_w1, input int e_w2, input int e_sum);
    chk({tag, " err_count"}, err4, e_err);
    chk({tag, " max_abs_err"}, max4, e_max);
    chk({tag, " worst_in1"}, w1_4, e_w1);
    chk({tag, " worst_in2"}, w2_4, e_w2);
    chk({tag, " sum_abs_err"}, sum4, e_sum);
    chk({tag, " done"}, done4, 1);
    chk({tag, " operands zero"}, {in1_4, in2_4}, 0);
  endtask

  // Start a 4-bit sweep and run it to completion, counting busy cycles and held cycles.
  task automatic sweep4(input int hold_at, input int hold_len, input bit repulse,
                        input bit rand_hold, output int cyc, output int held);
    int guard;
    cyc = 0; held = 0; guard = 0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk("start busy", busy4, 1);
    chk("start done clear", done4, 0);
    chk("start err clear", err4, 0);
    chk("start sum clear", sum4, 0);
    chk("start max clear", max4, 0);
    chk("start pair zero", {in1_4, in2_4}, 0);
    while (!done4 && guard < 3000) begin
      guard++;
      if (busy4) cyc++;
      if (rand_hold) hold4 = ($urandom_range(0, 3) == 0);
      else           hold4 = (int'({in1_4, in2_4}) == hold_at) && (held < hold_len);
      start4 = hold4 & repulse;
      if (hold4) held++;
      @(negedge clk);
    end
    hold4 = 1'b0; start4 = 1'b0;
    chk("sweep4 completes", done4, 1);
  endtask

  typedef struct {
    int mode; int err; int mx; int w1; int w2; int sum;
  } vec_t;
  vec_t tbl [3];

  initial begin
    int cyc, held, guard;
    int e_err, e_max, e_w1, e_w2, e_sum;
    rst8 = 1'b1; start8 = 1'b0; hold8 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; hold4 = 1'b0;
    for (int i = 0; i < 256; i++) mask_tab[i] = 5'd0;
    tbl[0] = '{0, 0,   0,  0,  0, 0};
    tbl[1] = '{1, 255, 30, 15, 15, 3840};
    tbl[2] = '{2, 256, 1,  0,  0, 256};

    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("reset busy", busy4, 0);
    chk("reset done", done4, 0);
    chk("reset err", err4, 0);
    chk("reset sum", sum4, 0);
    chk("reset operands", {in1_4, in2_4}, 0);
    chk("reset8 outputs", {busy8, done8, err8, max8, w1_8, w2_8, sum8, in1_8, in2_8}, 0);

    // Fixed models, each sweep after the first starting back-to-back from DONE
    for (int i = 0; i < 3; i++) begin
      mode4 = tbl[i].mode;
      sweep4(-1, 0, 1'b0, 1'b0, cyc, held);
      chk("table cycles", cyc, 256);
      chk_stats4("table", tbl[i].err, tbl[i].mx, tbl[i].w1, tbl[i].w2, tbl[i].sum);
    end

    // Random error masks with random hold cycles against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++)
        mask_tab[i] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      mode4 = 3;
      ref4(mode4, e_err, e_max, e_w1, e_w2, e_sum);
      sweep4(-1, 0, 1'b0, 1'b1, cyc, held);
      chk("random cycles", cyc, 256 + held);
      chk_stats4("random", e_err, e_max, e_w1, e_w2, e_sum);
    end

    // Ten held cycles at pair 100 with start re-pulsed while running
    sweep4(100, 10, 1'b1, 1'b0, cyc, held);
    chk("hold count", held, 10);
    chk("hold cycles", cyc, 266);
    chk_stats4("hold", e_err, e_max, e_w1, e_w2, e_sum);

    // Reset mid-sweep, then a clean rerun
    mode4 = 2;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    guard = 0;
    while (int'({in1_4, in2_4}) != 100 && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    chk("reach pair 100", {in1_4, in2_4}, 100);
    chk("midsweep err nonzero", err4, 100);
    rst4 = 1'b1;
    @(negedge clk); rst4 = 1'b0;
    chk("midrst busy", busy4, 0);
    chk("midrst done", done4, 0);
    chk("midrst stats", {err4, max4, w1_4, w2_4, sum4}, 0);
    chk("midrst operands", {in1_4, in2_4}, 0);
    sweep4(-1, 0, 1'b0, 1'b0, cyc, held);
    chk("rerun cycles", cyc, 256);
    chk_stats4("rerun", 256, 1, 0, 0, 256);

    // Full 8-bit sweep with a stuck-at-zero adder
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    cyc = 0; guard = 0;
    while (!done8 && guard < 70000) begin
      guard++;
      if (busy8) cyc++;
      @(negedge clk);
    end
    chk("w8 done", done8, 1);
    chk("w8 cycles", cyc, 65536);
    chk("w8 err_count", err8, 65535);
    chk("w8 max_abs_err", max8, 510);
    chk("w8 worst_in1", w1_8, 255);
    chk("w8 worst_in2", w2_8, 255);
    chk("w8 sum_abs_err", sum8, 16711680);
    chk("w8 busy low", busy8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_adder_error_profiler.md
Name: approx_adder_error_profiler

Overview:
- Sequential error-characterisation engine for the approximate ripple-carry adders in this library. It sits on the consumer side of an adder under test.
- Sweeps every operand pair into the adder, reads back the adder's sum and compares it with the exact sum.
- Accumulates error-rate, worst-case and absolute-error statistics, so the MAE and power figures reported for each adder variant can be reproduced in simulation or on an FPGA.

Parameters:
- WIDTH, 8, operand width of the adder under test; its sum output is WIDTH+1 bits.
- CNT_W, 2*WIDTH+1, width of the erroneous-pair counter (holds up to 2^(2*WIDTH)).
- SUM_W, 3*WIDTH+1, width of the absolute-error accumulator (no overflow possible).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sampled in IDLE or DONE; begins a new sweep.
- hold  in  1  while high in RUN, the sweep freezes: no evaluation, no counter advance.
- dut_in1  out  WIDTH  registered operand A driven to the adder under test.
- dut_in2  out  WIDTH  registered operand B driven to the adder under test.
- dut_out  in  WIDTH+1  combinational sum returned by the adder under test.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; held until the next start or rst.
- err_count  out  CNT_W  number of pairs with dut_out != exact sum.
- max_abs_err  out  WIDTH+1  largest |dut_out - exact|.
- worst_in1  out  WIDTH  operand A of the first pair reaching max_abs_err.
- worst_in2  out  WIDTH  operand B of that pair.
- sum_abs_err  out  SUM_W  sum of |dut_out - exact| over all pairs.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state IDLE; every output 0; busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: next cycle state=RUN, busy=1, done=0. Same edge clears all statistics and sets {dut_in1,dut_in2}=0.
- start while in RUN: ignored.
- RUN cycle with hold=0:
  - The current pair a=dut_in1, b=dut_in2 is evaluated against dut_out in the same cycle (the adder under test is combinational).
  - exact = a+b, computed at WIDTH+1 bits.
  - e = |dut_out - exact|, computed with an extra sign bit, no wrap.
  - On the edge: if e!=0, err_count++. sum_abs_err += e.
  - If e > max_abs_err (strictly greater): max_abs_err=e and worst_in1/worst_in2 = a/b. First occurrence wins on ties.
  - Pair counter {dut_in1,dut_in2} (2*WIDTH bits, dut_in2 is the LSBs) increments by 1.
- Last pair: when {a,b} is all ones in a non-hold RUN cycle, that pair is accumulated, the counter wraps to 0, state=DONE, busy=0, done=1.
- hold=1 in RUN: no statistic or counter change. Operands are stable. State stays RUN.
- Latency: start asserted at cycle t puts the sweep in RUN from t+1. done is first visible at t+1+2^(2*WIDTH)+H, where H is the number of held RUN cycles.
- DONE: all statistics stable and readable. dut_in1/dut_in2 = 0.
- rst mid-sweep: next cycle IDLE with all outputs zero. No partial results are retained.
- start and rst asserted in the same cycle: rst wins.
- Widths guarantee no accumulator overflow:
  - err_count max = 2^(2*WIDTH).
  - sum_abs_err max < 2^(2*WIDTH) * 2^(WIDTH+1).

Test Plan:
- Exact-adder DUT model, WIDTH=8, start pulse -> done after 65536 RUN cycles. err_count=0, max_abs_err=0, worst=(0,0), sum_abs_err=0.
- Stuck-at-zero DUT model (dut_out=0), WIDTH=8 -> err_count=65535, max_abs_err=510, worst=(255,255), sum_abs_err=16711680.
- LSB-flip DUT model (dut_out = exact ^ 1) -> err_count=65536, max_abs_err=1, worst=(0,0), sum_abs_err=65536.
- Hold: assert hold for 10 cycles at pair 1000 and start re-pulsed during RUN -> done exactly 10 cycles late, statistics identical to the unheld run, re-pulse ignored.
- Reset mid-sweep at pair 30000, then a new start -> all outputs 0 one cycle after rst. The new sweep completes with correct full-sweep values.
- WIDTH=4 build with LSB-flip model -> done after 256 RUN cycles, err_count=256, sum_abs_err=256. Back-to-back start in DONE clears the statistics and reruns.
